// File: rtl/ram_arb_pkg.sv
//------------------------------------------------------------------------------
// Module  : ram_arb_pkg
// Brief   : Shared FSM/owner encodings and defaults for the Data_RAM arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC     = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam int c_starve_max_default = 15;

endpackage

`default_nettype wire

// File: rtl/ram_arb_if.sv
//------------------------------------------------------------------------------
// Module  : ram_arb_if
// Brief   : CPU and DMA requester handshake bundle for the Data_RAM arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ram_arb_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;

    // Requester side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata
    );

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata
    );
endinterface

`default_nettype wire

// File: rtl/ram_arb_pick.sv
//------------------------------------------------------------------------------
// Module  : ram_arb_pick
// Brief   : Combinational winner select between CPU and DMA requests.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  wire logic cpu_req,
    input  wire logic dma_req,
    input  wire logic prefer_dma,
    output logic      any_req,
    output owner_t    winner
);

    // A lone requester always wins; prefer_dma only breaks ties.
    always_comb begin
        any_req = cpu_req | dma_req;
        winner  = OWN_CPU;
        if (dma_req && (!cpu_req || prefer_dma)) begin
            winner = OWN_DMA;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
//------------------------------------------------------------------------------
// Module  : ram_arbiter
// Brief   : Two-port (CPU/DMA) arbiter onto a single 1-cycle-latency Data_RAM.
//           Define RAM_ARB_RR_EN for round-robin; default is fixed priority
//           with a DMA starvation guard.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = c_starve_max_default
) (
    input  wire logic          clk,
    input  wire logic          RSTN,
    ram_arb_if.slave           bus,
    output logic               ram_we,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_din,
    input  wire logic [DW-1:0] ram_dout,
    output logic               busy
);

    state_t        r_state;
    owner_t        r_owner;
    logic          r_ram_we;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_din;
    logic          r_cpu_gnt;
    logic          r_dma_gnt;
    logic          r_cpu_rvalid;
    logic          r_dma_rvalid;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_dma_rdata;

    logic          w_any_req;
    logic          w_prefer_dma;
    owner_t        w_winner;
    logic          w_win_we;
    logic [AW-1:0] w_win_addr;
    logic [DW-1:0] w_win_wdata;

    ram_arb_pick u_pick (
        .cpu_req    (bus.cpu_req),
        .dma_req    (bus.dma_req),
        .prefer_dma (w_prefer_dma),
        .any_req    (w_any_req),
        .winner     (w_winner)
    );

    assign w_win_we    = (w_winner == OWN_DMA) ? bus.dma_we    : bus.cpu_we;
    assign w_win_addr  = (w_winner == OWN_DMA) ? bus.dma_addr  : bus.cpu_addr;
    assign w_win_wdata = (w_winner == OWN_DMA) ? bus.dma_wdata : bus.cpu_wdata;

`ifdef RAM_ARB_RR_EN
    logic r_rr_ptr;

    // Pointer names the port preferred on the next tie: the one not just served.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_rr_ptr <= 1'b0;
        end else if (r_state == IDLE && w_any_req) begin
            r_rr_ptr <= (w_winner == OWN_CPU);
        end
    end

    assign w_prefer_dma = r_rr_ptr;
`else
    localparam logic [3:0] c_starve_max = (STARVE_MAX > 15) ? 4'hF : 4'(STARVE_MAX);

    logic [3:0] r_starve;

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_starve <= 4'd0;
        end else if (r_state == IDLE && w_any_req) begin
            if (w_winner == OWN_DMA) begin
                r_starve <= 4'd0;
            end else if (bus.dma_req && r_starve != 4'hF) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end

    assign w_prefer_dma = (r_starve == c_starve_max);
`endif

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_state      <= IDLE;
            r_owner      <= OWN_CPU;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_cpu_gnt    <= 1'b0;
            r_dma_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
        end else begin
            r_ram_we     <= 1'b0;
            r_cpu_gnt    <= 1'b0;
            r_dma_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner    <= w_winner;
                        r_ram_we   <= w_win_we;
                        r_ram_addr <= w_win_addr;
                        r_ram_din  <= w_win_wdata;
                        r_cpu_gnt  <= (w_winner == OWN_CPU);
                        r_dma_gnt  <= (w_winner == OWN_DMA);
                        r_state    <= ACC;
                    end
                end
                ACC: begin
                    if (r_ram_we) begin
                        r_state <= IDLE;
                    end else begin
                        r_cpu_rvalid <= (r_owner == OWN_CPU);
                        r_dma_rvalid <= (r_owner == OWN_DMA);
                        r_state      <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (r_owner == OWN_CPU) begin
                        r_cpu_rdata <= ram_dout;
                    end else begin
                        r_dma_rdata <= ram_dout;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // RAM data is only valid during RD_WAIT, so it is forwarded while rvalid is
    // high and the captured copy holds it afterwards.
    assign bus.cpu_rdata  = r_cpu_rvalid ? ram_dout : r_cpu_rdata;
    assign bus.dma_rdata  = r_dma_rvalid ? ram_dout : r_dma_rdata;
    assign bus.cpu_gnt    = r_cpu_gnt;
    assign bus.dma_gnt    = r_dma_gnt;
    assign bus.cpu_rvalid = r_cpu_rvalid;
    assign bus.dma_rvalid = r_dma_rvalid;

    assign ram_we   = r_ram_we;
    assign ram_addr = r_ram_addr;
    assign ram_din  = r_ram_din;
    assign busy     = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_ram_arbiter
// Brief   : Directed, table-driven self-checking bench for ram_arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_arbiter;

`ifdef RAM_ARB_RR_EN
    localparam bit c_rr = 1'b1;
`else
    localparam bit c_rr = 1'b0;
`endif

    logic        clk;
    logic        RSTN;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        busy;

    int n_pass;
    int n_total;

    logic [31:0] mem [0:1023];

    ram_arb_if #(.AW(10), .DW(32)) bus ();

    ram_arbiter #(.AW(10), .DW(32), .STARVE_MAX(15)) dut (
        .clk      (clk),
        .RSTN     (RSTN),
        .bus      (bus),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data_RAM with one cycle of read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    typedef struct {
        logic        cpu_req;
        logic        cpu_we;
        logic [9:0]  cpu_addr;
        logic [31:0] cpu_wdata;
        logic        dma_req;
        logic        dma_we;
        logic [9:0]  dma_addr;
        logic [31:0] dma_wdata;
        logic        exp_dma;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        RSTN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        RSTN = 1'b1;
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic        ewe;
        logic [9:0]  ea;
        logic [31:0] ed;
        ewe = v.exp_dma ? v.dma_we    : v.cpu_we;
        ea  = v.exp_dma ? v.dma_addr  : v.cpu_addr;
        ed  = v.exp_dma ? v.dma_wdata : v.cpu_wdata;
        @(negedge clk);
        bus.cpu_req = v.cpu_req; bus.cpu_we = v.cpu_we;
        bus.cpu_addr = v.cpu_addr; bus.cpu_wdata = v.cpu_wdata;
        bus.dma_req = v.dma_req; bus.dma_we = v.dma_we;
        bus.dma_addr = v.dma_addr; bus.dma_wdata = v.dma_wdata;
        @(negedge clk);
        check({tag, " cpu_gnt"},  bus.cpu_gnt, !v.exp_dma);
        check({tag, " dma_gnt"},  bus.dma_gnt, v.exp_dma);
        check({tag, " ram_we"},   ram_we, ewe);
        check({tag, " ram_addr"}, ram_addr, ea);
        check({tag, " ram_din"},  ram_din, ed);
        check({tag, " busy_acc"}, busy, 1'b1);
        idle_inputs();
        if (!ewe) begin
            @(negedge clk);
            check({tag, " own_rvalid"}, v.exp_dma ? bus.dma_rvalid : bus.cpu_rvalid, 1'b1);
            check({tag, " oth_rvalid"}, v.exp_dma ? bus.cpu_rvalid : bus.dma_rvalid, 1'b0);
            check({tag, " rdata"},  v.exp_dma ? bus.dma_rdata : bus.cpu_rdata, v.exp_rdata);
            check({tag, " ram_we_rd"}, ram_we, 1'b0);
        end
        @(negedge clk);
        check({tag, " busy_idle"}, busy, 1'b0);
        if (!ewe) begin
            check({tag, " rdata_hold"}, v.exp_dma ? bus.dma_rdata : bus.cpu_rdata, v.exp_rdata);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t hv;
        int   n_dma_gnt;
        int   n_ram_we;
        int   n_rv;
        logic found;
        logic exp_dma;

        n_pass  = 0;
        n_total = 0;
        RSTN    = 1'b0;
        idle_inputs();

        // Vectors: owner and read data are hand-derived per arbitration mode.
        vecs[0] = '{1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 10'h005, 32'h0, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b1, 10'h3FF, 32'h12345678, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b0, 10'h3FF, 32'h0, 1'b1, 32'h12345678};
        vecs[4] = '{1'b1, 1'b1, 10'h010, 32'hA5A5A5A5, 1'b1, 1'b1, 10'h011, 32'h5A5A5A5A, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 10'h010, 32'h0, 1'b1, 1'b0, 10'h005, 32'h0,
                    c_rr, c_rr ? 32'hDEADBEEF : 32'hA5A5A5A5};
        vecs[6] = '{1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b0, 10'h010, 32'h0, 1'b1, 32'hA5A5A5A5};
        vecs[7] = '{1'b1, 1'b1, 10'h000, 32'hFFFFFFFF, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b0, 10'h000, 32'h0, 1'b1, 32'hFFFFFFFF};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst cpu_gnt", bus.cpu_gnt, 1'b0);
        check("rst dma_gnt", bus.dma_gnt, 1'b0);
        check("rst rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, 2'b00);
        check("rst ram_we", ram_we, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst ram_addr", ram_addr, 10'h0);
        check("rst ram_din", ram_din, 32'h0);
        check("rst rdata", {bus.cpu_rdata, bus.dma_rdata}, 64'h0);
        RSTN = 1'b1;

        for (int i = 0; i < 9; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // DMA pulse during CPU's ACC must never be served
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'h020; bus.cpu_wdata = 32'h0BADF00D;
        @(negedge clk);
        check("pulse cpu_gnt", bus.cpu_gnt, 1'b1);
        n_ram_we  = ram_we ? 1 : 0;
        n_dma_gnt = 0;
        idle_inputs();
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 10'h123; bus.dma_wdata = 32'hCAFEF00D;
        @(negedge clk);
        idle_inputs();
        if (ram_we) n_ram_we++;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.dma_gnt) n_dma_gnt++;
            if (ram_we) n_ram_we++;
        end
        check("pulse dma_gnt_count", n_dma_gnt, 0);
        check("pulse ram_we_count", n_ram_we, 1);

        // Reset during RD_WAIT of a DMA read
        @(negedge clk);
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 10'h3FF;
        @(negedge clk);
        check("rstrd dma_gnt", bus.dma_gnt, 1'b1);
        idle_inputs();
        @(posedge clk);
        #1 RSTN = 1'b0;
        @(negedge clk);
        check("rstrd dma_rvalid", bus.dma_rvalid, 1'b0);
        check("rstrd busy", busy, 1'b0);
        check("rstrd ram_addr", ram_addr, 10'h0);
        check("rstrd ram_din", ram_din, 32'h0);
        check("rstrd rdata", {bus.cpu_rdata, bus.dma_rdata}, 64'h0);
        @(negedge clk);
        RSTN = 1'b1;
        n_rv = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.dma_rvalid || bus.dma_gnt) n_rv++;
        end
        check("rstrd no_late_pulse", n_rv, 0);
        hv = '{1'b1, 1'b1, 10'h040, 32'h13579BDF, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 32'h0};
        apply(hv, "post_rst");

        // Both requesters held high continuously from a fresh reset
        reset_dut();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'h100; bus.cpu_wdata = 32'h11111111;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 10'h200; bus.dma_wdata = 32'h22222222;
        for (int g = 0; g < 34; g++) begin
            found = 1'b0;
            for (int w = 0; w < 4; w++) begin
                @(negedge clk);
                if (bus.cpu_gnt || bus.dma_gnt) begin
                    found = 1'b1;
                    break;
                end
            end
            check($sformatf("hold gnt_seen%0d", g), found, 1'b1);
            if (!found) break;
            exp_dma = c_rr ? ((g % 2) == 1) : ((g % 16) == 15);
            check($sformatf("hold gnt_excl%0d", g), bus.cpu_gnt & bus.dma_gnt, 1'b0);
            check($sformatf("hold owner%0d", g), bus.dma_gnt, exp_dma);
        end
        idle_inputs();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
